// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared types and constants for the transaction-layer state controller
package tl_pkg;

  localparam int PTR_W  = 3;
  localparam int DEF_AF = 6;
  localparam int DEF_AE = 1;

  // One-hot state codes decoded directly by the referees and FIFOs.
  // ERROR is all-zero so no downstream decoder matches and the datapath holds.
  typedef enum logic [3:0] {
    ST_ERROR  = 4'b0000,
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tl_state_e;

  // A threshold pair is usable only if almost-full is non-zero and strictly above almost-empty.
  function automatic logic cfg_valid(input logic [PTR_W-1:0] af, input logic [PTR_W-1:0] ae);
    return (af != '0) && (ae < af);
  endfunction

endpackage

// File: rtl/tl_idle_timer.sv
// rtl/tl_idle_timer.sv - counts consecutive all-empty cycles, flags the one that reaches HOLD
module tl_idle_timer #(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW:0] HOLD_V = (CW + 1)'(HOLD);

  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_next;

  assign cnt_next = {1'b0, cnt_q} + (CW + 1)'(1);

  // done fires on the cycle whose increment would reach HOLD, so the caller moves on that edge
  assign done = inc && !clear && (cnt_next >= HOLD_V);

  // Counter restarts on clear or when the hold is reached, so it never exceeds HOLD-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || done) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tl_state_ctrl.sv
// rtl/tl_state_ctrl.sv - transaction-layer main FSM with threshold config and error freeze
module tl_state_ctrl
  import tl_pkg::*;
#(
  parameter int NUM_FIFOS = 8,
  parameter int IDLE_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [PTR_W-1:0]     umbral_af_in,
  input  logic [PTR_W-1:0]     umbral_ae_in,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_err,
  output logic [3:0]           state,
  output logic [PTR_W-1:0]     umbral_af,
  output logic [PTR_W-1:0]     umbral_ae,
  output logic                 idle_out,
  output logic [NUM_FIFOS-1:0] error_out,
  output logic                 cfg_err,
  output logic                 init_pending
);

  tl_state_e state_q;
  tl_state_e state_d;
  logic      pend_d;
  logic      all_empty;
  logic      any_err;
  logic      timer_done;

  assign all_empty = &fifo_empty;
  assign any_err   = |fifo_err;
  assign state     = state_q;

  // The drain count only runs while ACTIVE with every FIFO empty and no error arriving
  tl_idle_timer #(
    .HOLD (IDLE_HOLD)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (reset_L),
    .clear ((state_q != ST_ACTIVE) || !all_empty || any_err),
    .inc   (all_empty),
    .done  (timer_done)
  );

  // Next-state and deferred-init decision; errors always beat init requests
  always_comb begin
    state_d = state_q;
    pend_d  = init_pending;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (any_err)         state_d = ST_ERROR;
        else if (init)       state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err) begin
          state_d = ST_ERROR;
        end else begin
          // init is never honoured mid-traffic; it waits until the FIFOs drain
          pend_d = init_pending | init;
          if (timer_done) state_d = pend_d ? ST_INIT : ST_IDLE;
        end
      end
      ST_ERROR: if (init) state_d = ST_INIT;
      default:  state_d = ST_RESET;
    endcase
    if (state_d == ST_INIT) pend_d = 1'b0;
  end

  // State, registered outputs and thresholds; thresholds only move while sitting in INIT
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_RESET;
      umbral_af    <= PTR_W'(DEF_AF);
      umbral_ae    <= PTR_W'(DEF_AE);
      idle_out     <= 1'b0;
      error_out    <= '0;
      cfg_err      <= 1'b0;
      init_pending <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_out     <= (state_d == ST_IDLE);
      init_pending <= pend_d;
      // Entering or staying in INIT wipes old error history but still records this cycle's pulses
      error_out    <= (state_d == ST_INIT) ? fifo_err : (error_out | fifo_err);
      if (state_q == ST_INIT) begin
        if (cfg_valid(umbral_af_in, umbral_ae_in)) begin
          umbral_af <= umbral_af_in;
          umbral_ae <= umbral_ae_in;
          cfg_err   <= 1'b0;
        end else begin
          umbral_af <= PTR_W'(DEF_AF);
          umbral_ae <= PTR_W'(DEF_AE);
          cfg_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_state_ctrl.sv
// tb/tb_tl_state_ctrl.sv - self-checking bench for tl_state_ctrl
module tb_tl_state_ctrl;

  localparam int HOLD = 2;
  localparam logic [3:0] S_RESET  = 4'b0001;
  localparam logic [3:0] S_INIT   = 4'b0010;
  localparam logic [3:0] S_IDLE   = 4'b0100;
  localparam logic [3:0] S_ACTIVE = 4'b1000;
  localparam logic [3:0] S_ERROR  = 4'b0000;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [2:0] af_in;
  logic [2:0] ae_in;
  logic [7:0] fifo_empty;
  logic [7:0] fifo_err;
  logic [3:0] state;
  logic [2:0] umbral_af;
  logic [2:0] umbral_ae;
  logic       idle_out;
  logic [7:0] error_out;
  logic       cfg_err;
  logic       init_pending;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_state;
  logic [2:0] m_af;
  logic [2:0] m_ae;
  logic [7:0] m_err;
  logic       m_cfg;
  logic       m_pend;
  int         m_cnt;

  always #5 clk = ~clk;

  tl_state_ctrl #(.NUM_FIFOS(8), .IDLE_HOLD(HOLD)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_af_in (af_in),
    .umbral_ae_in (ae_in),
    .fifo_empty   (fifo_empty),
    .fifo_err     (fifo_err),
    .state        (state),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .idle_out     (idle_out),
    .error_out    (error_out),
    .cfg_err      (cfg_err),
    .init_pending (init_pending)
  );

  task automatic model_reset();
    m_state = S_RESET; m_af = 3'd6; m_ae = 3'd1; m_err = 8'h00;
    m_cfg = 1'b0; m_pend = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [3:0] nx;
    logic all_e;
    all_e = (fifo_empty == 8'hFF);
    nx = m_state;
    if (m_state == S_RESET) begin
      nx = S_INIT; m_cnt = 0;
    end else if (m_state == S_INIT) begin
      if (af_in != 3'd0 && ae_in < af_in) begin
        m_af = af_in; m_ae = ae_in; m_cfg = 1'b0;
      end else begin
        m_af = 3'd6; m_ae = 3'd1; m_cfg = 1'b1;
      end
      nx = init ? S_INIT : S_IDLE; m_cnt = 0;
    end else if (m_state == S_IDLE) begin
      m_cnt = 0;
      if (fifo_err != 8'h00) nx = S_ERROR;
      else if (init) nx = S_INIT;
      else if (!all_e) nx = S_ACTIVE;
    end else if (m_state == S_ACTIVE) begin
      if (fifo_err != 8'h00) begin
        nx = S_ERROR; m_cnt = 0;
      end else begin
        if (init) m_pend = 1'b1;
        m_cnt = all_e ? m_cnt + 1 : 0;
        if (m_cnt == HOLD) begin
          m_cnt = 0;
          nx = m_pend ? S_INIT : S_IDLE;
        end
      end
    end else begin
      m_cnt = 0;
      nx = init ? S_INIT : S_ERROR;
    end
    if (nx == S_INIT) begin
      m_err = fifo_err; m_pend = 1'b0;
    end else begin
      m_err = m_err | fifo_err;
    end
    m_state = nx;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_L) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; init = 1'b0; af_in = 3'd0; ae_in = 3'd0;
    fifo_empty = 8'hFF; fifo_err = 8'h00;
    model_reset();
    repeat (3) tick();
    checks++; if (state !== S_RESET) begin errors++; $display("FAIL rst_state: got %b exp %b", state, S_RESET); end
    checks++; if ({umbral_af, umbral_ae} !== {3'd6, 3'd1}) begin errors++; $display("FAIL rst_thr: got %0d/%0d exp 6/1", umbral_af, umbral_ae); end
    checks++; if ({idle_out, error_out, cfg_err, init_pending} !== 11'd0) begin errors++; $display("FAIL rst_flags: idle=%b err=%h cfg=%b pend=%b exp all 0", idle_out, error_out, cfg_err, init_pending); end
    reset_L = 1'b1; init = 1'b1; af_in = 3'd5; ae_in = 3'd2;
    tick();
    checks++; if (state !== S_INIT) begin errors++; $display("FAIL rel_init1: got %b exp %b", state, S_INIT); end
    tick();
    checks++; if (state !== S_INIT) begin errors++; $display("FAIL rel_init2: got %b exp %b", state, S_INIT); end
    init = 1'b0;
    tick();
    checks++; if (state !== S_IDLE || idle_out !== 1'b1) begin errors++; $display("FAIL rel_idle: got %b idle=%b exp %b idle=1", state, idle_out, S_IDLE); end
    checks++; if ({umbral_af, umbral_ae, cfg_err} !== {3'd5, 3'd2, 1'b0}) begin errors++; $display("FAIL rel_cfg: got %0d/%0d cfg=%b exp 5/2 cfg=0", umbral_af, umbral_ae, cfg_err); end
  endtask

  task automatic test_cfg();
    logic [2:0] t_af [5];
    logic [2:0] t_ae [5];
    logic       t_ok [5];
    t_af = '{3'd2, 3'd7, 3'd4, 3'd0, 3'd5};
    t_ae = '{3'd3, 3'd6, 3'd4, 3'd0, 3'd2};
    t_ok = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      init = 1'b1; af_in = t_af[i]; ae_in = t_ae[i];
      tick();
      init = 1'b0;
      tick();
      checks++;
      if (state !== S_IDLE || cfg_err !== !t_ok[i]) begin
        errors++; $display("FAIL cfg_flag[%0d]: state=%b cfg=%b exp %b cfg=%b", i, state, cfg_err, S_IDLE, !t_ok[i]);
      end
      checks++;
      if (umbral_af !== (t_ok[i] ? t_af[i] : 3'd6) || umbral_ae !== (t_ok[i] ? t_ae[i] : 3'd1)) begin
        errors++; $display("FAIL cfg_thr[%0d]: got %0d/%0d for req %0d/%0d", i, umbral_af, umbral_ae, t_af[i], t_ae[i]);
      end
    end
  endtask

  task automatic test_active_idle();
    fifo_empty = 8'hFE; tick();
    checks++; if (state !== S_ACTIVE) begin errors++; $display("FAIL go_active: got %b exp %b", state, S_ACTIVE); end
    fifo_empty = 8'hFF; tick();
    checks++; if (state !== S_ACTIVE) begin errors++; $display("FAIL hold_1cyc: got %b exp %b", state, S_ACTIVE); end
    tick();
    checks++; if (state !== S_IDLE || idle_out !== 1'b1) begin errors++; $display("FAIL drain_idle: got %b idle=%b exp %b", state, idle_out, S_IDLE); end
    fifo_empty = 8'hFE; tick();
    fifo_empty = 8'hFF; tick();
    fifo_empty = 8'h7F; tick();
    fifo_empty = 8'hFF; tick();
    checks++; if (state !== S_ACTIVE) begin errors++; $display("FAIL blip_reset: got %b exp %b", state, S_ACTIVE); end
    tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL blip_idle: got %b exp %b", state, S_IDLE); end
  endtask

  task automatic test_init_pending();
    fifo_empty = 8'hFE; tick();
    init = 1'b1; fifo_empty = 8'h7F; tick();
    checks++; if (state !== S_ACTIVE || init_pending !== 1'b1) begin errors++; $display("FAIL pend_set: got %b pend=%b exp %b pend=1", state, init_pending, S_ACTIVE); end
    init = 1'b0; tick();
    fifo_empty = 8'hFF; tick();
    checks++; if (state !== S_ACTIVE || init_pending !== 1'b1) begin errors++; $display("FAIL pend_hold: got %b pend=%b exp %b pend=1", state, init_pending, S_ACTIVE); end
    tick();
    checks++; if (state !== S_INIT || init_pending !== 1'b0) begin errors++; $display("FAIL pend_init: got %b pend=%b exp %b pend=0", state, init_pending, S_INIT); end
    tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL pend_idle: got %b exp %b", state, S_IDLE); end
  endtask

  task automatic test_error();
    fifo_empty = 8'hFE; tick();
    fifo_err = 8'h04; tick();
    fifo_err = 8'h00;
    checks++; if (state !== S_ERROR || error_out !== 8'h04) begin errors++; $display("FAIL err_enter: got %b err=%h exp %b err=04", state, error_out, S_ERROR); end
    repeat (2) tick();
    checks++; if (state !== S_ERROR || error_out !== 8'h04) begin errors++; $display("FAIL err_hold: got %b err=%h exp %b err=04", state, error_out, S_ERROR); end
    init = 1'b1; tick();
    checks++; if (state !== S_INIT || error_out !== 8'h00) begin errors++; $display("FAIL err_exit: got %b err=%h exp %b err=00", state, error_out, S_INIT); end
    init = 1'b0; fifo_empty = 8'hFF; tick();
    fifo_err = 8'h10; init = 1'b1; tick();
    checks++; if (state !== S_ERROR || error_out !== 8'h10) begin errors++; $display("FAIL err_wins: got %b err=%h exp %b err=10", state, error_out, S_ERROR); end
    fifo_err = 8'h00; init = 1'b0; tick();
    checks++; if (state !== S_ERROR) begin errors++; $display("FAIL err_stick: got %b exp %b", state, S_ERROR); end
    init = 1'b1; tick();
    init = 1'b0; tick();
    checks++; if (state !== S_IDLE || error_out !== 8'h00) begin errors++; $display("FAIL err_recover: got %b err=%h exp %b err=00", state, error_out, S_IDLE); end
  endtask

  task automatic test_async_reset();
    fifo_empty = 8'hFE; tick();
    init = 1'b1; fifo_empty = 8'h7F; tick();
    init = 1'b0;
    #3 reset_L = 1'b0;
    #1 model_reset();
    checks++; if (state !== S_RESET || init_pending !== 1'b0 || idle_out !== 1'b0) begin errors++; $display("FAIL async_state: got %b pend=%b idle=%b exp %b pend=0 idle=0", state, init_pending, idle_out, S_RESET); end
    checks++; if ({umbral_af, umbral_ae, cfg_err, error_out} !== {3'd6, 3'd1, 1'b0, 8'h00}) begin errors++; $display("FAIL async_regs: got %0d/%0d cfg=%b err=%h exp 6/1 0 00", umbral_af, umbral_ae, cfg_err, error_out); end
    tick();
    #2 reset_L = 1'b1; af_in = 3'd5; ae_in = 3'd2; fifo_empty = 8'hFF;
    tick();
    checks++; if (state !== S_INIT) begin errors++; $display("FAIL async_rel: got %b exp %b", state, S_INIT); end
    tick();
    checks++; if (state !== S_IDLE || umbral_af !== 3'd5 || umbral_ae !== 3'd2) begin errors++; $display("FAIL async_cfg: got %b %0d/%0d exp %b 5/2", state, umbral_af, umbral_ae, S_IDLE); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      init       = ($urandom_range(0, 9) == 0);
      af_in      = 3'($urandom_range(0, 7));
      ae_in      = 3'($urandom_range(0, 7));
      fifo_empty = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      fifo_err   = ($urandom_range(0, 29) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
      tick();
      checks++;
      if (state !== m_state) begin
        errors++; $display("FAIL rnd_state[%0d]: got %b exp %b", n, state, m_state);
      end
      checks++;
      if ({umbral_af, umbral_ae, idle_out, error_out, cfg_err, init_pending} !==
          {m_af, m_ae, (m_state == S_IDLE), m_err, m_cfg, m_pend}) begin
        errors++;
        $display("FAIL rnd_outs[%0d]: got af=%0d ae=%0d idle=%b err=%h cfg=%b pend=%b exp af=%0d ae=%0d idle=%b err=%h cfg=%b pend=%b",
                 n, umbral_af, umbral_ae, idle_out, error_out, cfg_err, init_pending,
                 m_af, m_ae, (m_state == S_IDLE), m_err, m_cfg, m_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_active_idle();
    test_init_pending();
    test_error();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
